hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Tracks in-flight register writers between decode and register-file commit; raises the decode-stage
//  stall (hazard) on RAW or status-flag dependences. Sits beside the decode stage: consumes its
//  src1/src2/two_src/dest/control outputs and drives its hazard input.
//  Keeps a DEPTH-entry shift register of {valid, dest, is_load, sets_flags}, one entry per downstream
//  stage, plus a saturating stall-cycle counter.
// PARAMETERS
//  DEPTH  2   stages between decode and RF commit (entry 0 = EXE, entry DEPTH-1 = last before WB)
//  CNT_W  16  width of stall_cnt
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  id_valid     in   1      decode holds a real instruction (0 = bubble)
//  src1         in   4      first source register (rn)
//  src2         in   4      second source register (rm, or rd for stores)
//  two_src      in   1      src2 is actually read
//  id_cond      in   4      condition field of decode instruction (4'hE = always)
//  id_wb_en     in   1      decode instruction writes dest
//  id_dest      in   4      decode destination register
//  id_mem_r_en  in   1      decode instruction is a load
//  id_s         in   1      decode instruction updates status flags
//  freeze       in   1      pipeline frozen (memory wait): scoreboard holds
//  flush        in   1      branch taken: decode instruction is discarded
//  hazard       out  1      stall decode this cycle (combinational)
//  busy         out  1      any entry valid (registered-state derived)
//  stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst): all entries valid=0,
//    dest=0, is_load=0, sets_flags=0; stall_cnt=0; hence hazard=0, busy=0 in the cycle after reset.
//  - Match m(e) = entry e valid & id_valid & (dest==src1 | (two_src & dest==src2)).
//  - Flag hazard fh = id_valid & (id_cond != 4'hE) & entry[0].sets_flags (flags commit at EXE end).
//  - hazard = (OR of m(e) over qualifying entries) | fh; latency 0 (pure function of state + inputs).
//  - Issue bit iss = id_valid & ~hazard & ~flush.
//  - Update on each clk edge when rst=0 and freeze=0:
//      entry[0] <= {iss & id_wb_en, id_dest, iss & id_mem_r_en, iss & id_s};
//      entry[i] <= entry[i-1] for 1 <= i < DEPTH; entry[DEPTH-1] retires (commit same cycle as WB,
//      RF write visible to decode reads, so no WB entry is needed).
//  - freeze=1: all entries and stall_cnt hold; hazard still evaluated from held state.
//  - flush=1 and freeze=0: bubble into entry[0]; older entries still shift (they are committed work).
//  - flush and hazard together: flush wins for insertion (bubble); hazard output unaffected.
//  - stall_cnt increments by 1 when hazard=1 & freeze=0 & rst=0; saturates at all-ones (no wrap).
//  - Entries with wb_en=0 but s=1 are kept (valid=0, sets_flags=1) so flag hazards still see them.
//  - Register 15 (PC) sources are matched like any other register; no special case.
//  - rst mid-stall: state clears on that edge; hazard drops next cycle regardless of inputs.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: decode assumed backed by EXE/MEM forwarding; only load-use stalls
//    remain -> qualifying entries = entry[0] with is_load=1 only; fh rule unchanged.
//  Not defined: every entry 0..DEPTH-1 qualifies (full interlock, no forwarding).
// TESTING
//  1 reset: assert rst 2 cycles with id_valid=1, src1=3 -> hazard=0, busy=0, stall_cnt=0.
//  2 RAW: issue ADD r3 (wb_en=1,dest=3); next cycle src1=3 -> hazard=1 for 2 cycles (no FWD),
//    0 cycles (HAZARD_FORWARDING_EN); stall_cnt=2 / 0.
//  3 load-use with HAZARD_FORWARDING_EN: LDR r5 then src2=5,two_src=1 -> hazard=1 exactly 1 cycle;
//    same with two_src=0 -> hazard=0.
//  4 flags: issue s=1 ALU op, next id_cond=4'h0 -> hazard=1 one cycle; id_cond=4'hE -> hazard=0.
//  5 freeze: RAW stall active, hold freeze=1 for 5 cycles -> hazard stays 1, stall_cnt unchanged,
//    entries unchanged; release -> stall completes on original schedule.
//  6 flush+saturate: flush=1 with id_wb_en=1,dest=7 -> next src1=7 gives hazard=0; CNT_W=2 forced
//    6 stall cycles -> stall_cnt=3 held.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard.
// Handshake: the decode stage presents an instruction with id_valid=1; the
// scoreboard accepts (issues) it on a clk edge where hazard=0, flush=0,
// freeze=0 and rst=0. While hazard=1 the decode stage must hold its
// instruction stable. hazard is combinational from the scoreboard state and
// the current decode fields.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;
    logic [3:0]       id_cond;
    logic             id_wb_en;
    logic [3:0]       id_dest;
    logic             id_mem_r_en;
    logic             id_s;
    logic             freeze;
    logic             flush;
    logic             hazard;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    // Decode/pipeline-control side.
    modport master (
        output id_valid, src1, src2, two_src, id_cond, id_wb_en, id_dest,
               id_mem_r_en, id_s, freeze, flush,
        input  hazard, busy, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, src1, src2, two_src, id_cond, id_wb_en, id_dest,
               id_mem_r_en, id_s, freeze, flush,
        output hazard, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers between decode and
// register-file commit and raises the decode stall on RAW or flag hazards.
// Optional feature macro: HAZARD_FORWARDING_EN. When defined, EXE/MEM
// forwarding is assumed and only load-use RAW hazards against entry 0 stall;
// otherwise every in-flight writer interlocks.
module hazard_scoreboard #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       is_load;
        logic       sets_flags;
    } entry_t;

    // entry 0 = EXE, entry DEPTH-1 = last stage before WB
    entry_t           pipe_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;

    logic [DEPTH-1:0] match;
    logic             raw_hit;
    logic             flag_hit;
    logic             hazard;
    logic             iss;
    logic             busy;

    // Per-entry source-operand match against the decode instruction.
    always_comb begin
        match = '0;
        for (int e = 0; e < DEPTH; e++) begin
            match[e] = pipe_q[e].valid & sb.id_valid &
                       ((pipe_q[e].dest == sb.src1) |
                        (sb.two_src & (pipe_q[e].dest == sb.src2)));
        end
    end

    // Combine qualifying matches and the flag dependence into the stall.
    always_comb begin
        raw_hit  = 1'b0;
`ifdef HAZARD_FORWARDING_EN
        // Forwarding covers ALU results; only a load in EXE cannot be bypassed.
        raw_hit  = match[0] & pipe_q[0].is_load;
`else
        raw_hit  = |match;
`endif
        // Flags are produced at the end of EXE, so only entry 0 can conflict.
        flag_hit = sb.id_valid & (sb.id_cond != 4'hE) & pipe_q[0].sets_flags;
        hazard   = raw_hit | flag_hit;
        iss      = sb.id_valid & ~hazard & ~sb.flush;
    end

    // Busy whenever any in-flight entry will still write the register file.
    always_comb begin
        busy = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            busy = busy | pipe_q[e].valid;
        end
    end

    // Shift the in-flight pipeline and count stall cycles; freeze holds all.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (!sb.freeze) begin
            pipe_q[0] <= '{valid:      iss & sb.id_wb_en,
                           dest:       sb.id_dest,
                           is_load:    iss & sb.id_mem_r_en,
                           sets_flags: iss & sb.id_s};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (hazard && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign sb.hazard    = hazard;
    assign sb.busy      = busy;
    assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an in-flight list model.
// Honours HAZARD_FORWARDING_EN the same way the design does.
module tb_hazard_scoreboard;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    logic started;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.CNT_W(16)) if0 ();
    hazard_scoreboard_if #(.CNT_W(2))  if1 ();

    assign if1.id_valid    = if0.id_valid;
    assign if1.src1        = if0.src1;
    assign if1.src2        = if0.src2;
    assign if1.two_src     = if0.two_src;
    assign if1.id_cond     = if0.id_cond;
    assign if1.id_wb_en    = if0.id_wb_en;
    assign if1.id_dest     = if0.id_dest;
    assign if1.id_mem_r_en = if0.id_mem_r_en;
    assign if1.id_s        = if0.id_s;
    assign if1.freeze      = if0.freeze;
    assign if1.flush       = if0.flush;

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .sb  (if0)
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .sb  (if1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each issued instruction is remembered with the advance count at which it
    // entered EXE; its age is how many unfrozen edges have passed since then.
    typedef struct {
        logic       wb;
        logic [3:0] dest;
        logic       ld;
        logic       s;
        int         born;
    } flight_t;

    flight_t flight_q[$];
    int      adv;
    int      exp_cnt16;
    int      exp_cnt2;

    always @(negedge clk) begin
        if (started) begin
            automatic logic raw = 1'b0;
            automatic logic fh  = 1'b0;
            automatic logic eb  = 1'b0;
            automatic logic eh;
            foreach (flight_q[k]) begin
                automatic int age = adv - flight_q[k].born;
                if (flight_q[k].wb) eb = 1'b1;
                if (flight_q[k].wb && if0.id_valid &&
                    ((flight_q[k].dest == if0.src1) ||
                     (if0.two_src && (flight_q[k].dest == if0.src2)))) begin
                    if (!FWD || (age == 0 && flight_q[k].ld)) raw = 1'b1;
                end
                if (age == 0 && flight_q[k].s && if0.id_valid && (if0.id_cond != 4'hE))
                    fh = 1'b1;
            end
            eh = raw | fh;
            check("hazard", 32'(if0.hazard), 32'(eh));
            check("hazard_w2", 32'(if1.hazard), 32'(eh));
            check("busy", 32'(if0.busy), 32'(eb));
            check("stall_cnt", 32'(if0.stall_cnt), 32'(exp_cnt16));
            check("stall_cnt_w2", 32'(if1.stall_cnt), 32'(exp_cnt2));

            // state transition at the coming posedge
            if (rst) begin
                flight_q.delete();
                exp_cnt16 = 0;
                exp_cnt2  = 0;
            end else if (!if0.freeze) begin
                if (eh) begin
                    if (exp_cnt16 < 65535) exp_cnt16++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                end
                adv++;
                if (if0.id_valid && !eh && !if0.flush) begin
                    flight_q.push_back('{wb: if0.id_wb_en, dest: if0.id_dest,
                                         ld: if0.id_mem_r_en, s: if0.id_s, born: adv});
                end
                for (int k = flight_q.size() - 1; k >= 0; k--) begin
                    if (adv - flight_q[k].born >= DEPTH) flight_q.delete(k);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic [3:0] cond, input logic wb,
                         input logic [3:0] dest, input logic ld, input logic s,
                         input logic frz, input logic fl, input logic r);
        @(posedge clk);
        #1;
        if0.id_valid    = v;
        if0.src1        = s1;
        if0.src2        = s2;
        if0.two_src     = two;
        if0.id_cond     = cond;
        if0.id_wb_en    = wb;
        if0.id_dest     = dest;
        if0.id_mem_r_en = ld;
        if0.id_s        = s;
        if0.freeze      = frz;
        if0.flush       = fl;
        rst             = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_h(input string name, input logic exp);
        @(negedge clk);
        check(name, 32'(if0.hazard), 32'(exp));
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'd15 : 4'(r);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        started   = 1'b0;
        adv       = 0;
        exp_cnt16 = 0;
        exp_cnt2  = 0;
        rst = 1'b1;
        if0.id_valid = 1'b1; if0.src1 = 4'd3; if0.src2 = 4'd0; if0.two_src = 1'b0;
        if0.id_cond = 4'hE; if0.id_wb_en = 1'b0; if0.id_dest = 4'd0;
        if0.id_mem_r_en = 1'b0; if0.id_s = 1'b0; if0.freeze = 1'b0; if0.flush = 1'b0;

        // reset: two cycles with a live source operand
        @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        check("rst_hazard", 32'(if0.hazard), 0);
        check("rst_busy", 32'(if0.busy), 0);
        check("rst_cnt", 32'(if0.stall_cnt), 0);
        drive(1, 3, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 1);
        expect_h("rst_hazard2", 1'b0);

        // RAW on r3
        drive(1, 0, 0, 0, 4'hE, 1, 3, 0, 0, 0, 0, 0);
        expect_h("raw_issue", 1'b0);
        drive(1, 3, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("raw_c1", !FWD);
        check("raw_busy", 32'(if0.busy), 1);
        drive(1, 3, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("raw_c2", !FWD);
        drive(1, 3, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("raw_c3", 1'b0);
        check("raw_cnt", 32'(if0.stall_cnt), FWD ? 0 : 2);
        idle(3);

        // load-use on r5 via src2
        drive(1, 0, 0, 0, 4'hE, 1, 5, 1, 0, 0, 0, 0);
        expect_h("ld_issue", 1'b0);
        drive(1, 0, 5, 1, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("ld_use_c1", 1'b1);
        drive(1, 0, 5, 1, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("ld_use_c2", !FWD);
        drive(1, 0, 5, 1, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("ld_use_c3", 1'b0);
        idle(3);
        drive(1, 0, 0, 0, 4'hE, 1, 5, 1, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("ld_one_src", 1'b0);
        idle(3);

        // flag hazard from an S op that writes no register
        drive(1, 1, 0, 0, 4'hE, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        expect_h("flag_cond", 1'b1);
        drive(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        expect_h("flag_done", 1'b0);
        idle(2);
        drive(1, 1, 0, 0, 4'hE, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("flag_always", 1'b0);
        idle(2);

        // freeze during a RAW stall on r4
        drive(1, 0, 0, 0, 4'hE, 1, 4, 0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("frz_pre", !FWD);
        for (int i = 0; i < 5; i++) begin
            drive(1, 4, 0, 0, 4'hE, 0, 0, 0, 0, 1, 0, 0);
            expect_h("frz_hold", !FWD);
            check("frz_busy", 32'(if0.busy), 1);
        end
        drive(1, 4, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("frz_rel", !FWD);
        drive(1, 4, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("frz_done", 1'b0);
        idle(3);

        // flush drops the decode writer of r7
        drive(1, 0, 0, 0, 4'hE, 1, 7, 0, 0, 0, 1, 0);
        drive(1, 7, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("flush_drop", 1'b0);
        idle(2);

        // reset in the middle of a stall
        drive(1, 0, 0, 0, 4'hE, 1, 6, 0, 0, 0, 0, 0);
        drive(1, 6, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 1);
        expect_h("rst_mid", !FWD);
        drive(1, 6, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        expect_h("rst_after", 1'b0);
        check("rst_after_cnt", 32'(if0.stall_cnt), 0);
        idle(2);

        // six flag stalls: 16-bit counter reaches 6, 2-bit counter saturates
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 4'hE, 0, 0, 0, 1, 0, 0, 0);
            drive(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        end
        idle(2);
        @(negedge clk);
        check("sat_cnt16", 32'(if0.stall_cnt), 6);
        check("sat_cnt2", 32'(if1.stall_cnt), 3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0, pick_reg(), pick_reg(), $urandom_range(0, 1),
                  (($urandom % 4) == 0) ? 4'($urandom_range(0, 13)) : 4'hE,
                  ($urandom % 4) != 0, pick_reg(), ($urandom % 4) == 0,
                  ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
                  ($urandom % 150) == 0);
        end
        idle(4);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
